// File: rtl/vga_pong_renderer.sv
// VGA timing generator and sprite compositor for the pong display path.
// Produces registered sync, colour and video_on outputs one pixel after the
// counters, composites ball / paddles / walls with a fixed priority, and
// latches object positions once per frame at the start of vertical blanking.
module vga_pong_renderer #(
  parameter int              CLK_DIV  = 2,
  parameter int              H_VA     = 640,
  parameter int              H_FP     = 16,
  parameter int              H_SP     = 96,
  parameter int              H_BP     = 48,
  parameter int              V_VA     = 480,
  parameter int              V_FP     = 10,
  parameter int              V_SP     = 2,
  parameter int              V_BP     = 33,
  parameter bit              SYNC_POL = 1'b0,
  parameter int              CW       = 4,
  parameter int              PAD_W    = 15,
  parameter int              PAD_H    = 80,
  parameter int              PAD_L_X  = 0,
  parameter int              PAD_R_X  = 625,
  parameter int              BALL     = 20,
  parameter int              WALL_H   = 6,
  parameter logic [3*CW-1:0] COL_PAD  = '1,
  parameter logic [3*CW-1:0] COL_BALL = '1,
  parameter logic [3*CW-1:0] COL_WALL = '1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [9:0]    bola_x,
  input  logic [9:0]    bola_y,
  input  logic [9:0]    barra_e_y,
  input  logic [9:0]    barra_d_y,
  output logic          HSync,
  output logic          VSync,
  output logic [CW-1:0] R,
  output logic [CW-1:0] G,
  output logic [CW-1:0] B,
  output logic          video_on,
  output logic          frame_start
);

  localparam int H_TOT = H_VA + H_FP + H_SP + H_BP;
  localparam int V_TOT = V_VA + V_FP + V_SP + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // All pixel arithmetic is 11 bits wide so position + size never wraps.
  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);
  localparam logic [10:0] HVA11   = 11'(H_VA);
  localparam logic [10:0] VVA11   = 11'(V_VA);
  localparam logic [10:0] HS_ON   = 11'(H_VA + H_FP);
  localparam logic [10:0] HS_OFF  = 11'(H_VA + H_FP + H_SP);
  localparam logic [10:0] VS_ON   = 11'(V_VA + V_FP);
  localparam logic [10:0] VS_OFF  = 11'(V_VA + V_FP + V_SP);
  localparam logic [10:0] BALL11  = 11'(BALL);
  localparam logic [10:0] PADW11  = 11'(PAD_W);
  localparam logic [10:0] PADH11  = 11'(PAD_H);
  localparam logic [10:0] PLX11   = 11'(PAD_L_X);
  localparam logic [10:0] PRX11   = 11'(PAD_R_X);
  localparam logic [10:0] WALLT11 = 11'(WALL_H);
  localparam logic [10:0] WALLB11 = 11'(V_VA - WALL_H);
  localparam logic [26:0] DISC_R2 = 27'(BALL * BALL);

  typedef struct packed {
    logic [10:0] bx;
    logic [10:0] by;
    logic [10:0] ey;
    logic [10:0] dy;
  } pos_t;

  logic [DW-1:0]     div_cnt;
  logic              pe;
  logic [10:0]       hcount, vcount;
  logic              frame_tick;
  pos_t              shadow;

  logic [10:0]       dx_off, dy_off;
  logic              in_box;
  logic signed [12:0] ax, ay;
  logic signed [25:0] ax2, ay2;
  logic [26:0]       disc;
  logic              ball_hit, pad_l_hit, pad_r_hit, wall_hit, visible;
  logic              hs_nxt, vs_nxt;
  logic [3*CW-1:0]   pix_col;

  // Pixel-clock divider; with CLK_DIV=1 the count stays at 0 and pe is constant.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)   div_cnt <= '0;
    else if (pe) div_cnt <= '0;
    else         div_cnt <= div_cnt + 1'b1;
  end

  assign pe = (div_cnt == DIV_LAST);

  // Raster position: hcount wraps every H_TOT pixels, vcount every V_TOT lines.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pe) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
    end
  end

  // First pixel of vertical blanking: the only point positions may change.
  assign frame_tick = pe && (hcount == 11'd0) && (vcount == VVA11);

  // Shadow copies of the positions, so a frame is always drawn from one snapshot.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shadow <= '{bx: 11'd310, by: 11'd230, ey: 11'd200, dy: 11'd200};
    end else if (frame_tick) begin
      shadow <= '{bx: {1'b0, bola_x},    by: {1'b0, bola_y},
                  ey: {1'b0, barra_e_y}, dy: {1'b0, barra_d_y}};
    end
  end

  // Ball: bounding box by unsigned offset (negative offsets wrap to huge values),
  // then a disc test in doubled coordinates centred on the box.
  assign dx_off = hcount - shadow.bx;
  assign dy_off = vcount - shadow.by;
  assign in_box = (dx_off < BALL11) && (dy_off < BALL11);
  assign ax     = $signed({1'b0, dx_off, 1'b1}) - $signed({2'b00, BALL11});
  assign ay     = $signed({1'b0, dy_off, 1'b1}) - $signed({2'b00, BALL11});
  assign ax2    = ax * ax;
  assign ay2    = ay * ay;
  assign disc   = {1'b0, ax2} + {1'b0, ay2};
  assign ball_hit = in_box && (disc <= DISC_R2);

  assign pad_l_hit = ((hcount - PLX11) < PADW11) && ((vcount - shadow.ey) < PADH11);
  assign pad_r_hit = ((hcount - PRX11) < PADW11) && ((vcount - shadow.dy) < PADH11);
  assign wall_hit  = (vcount < WALLT11) || (vcount >= WALLB11);
  assign visible   = (hcount < HVA11) && (vcount < VVA11);

  assign hs_nxt = ((hcount >= HS_ON) && (hcount < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
  assign vs_nxt = ((vcount >= VS_ON) && (vcount < VS_OFF)) ? SYNC_POL : ~SYNC_POL;

  // Priority compositor; everything outside the visible area is black.
  always_comb begin
    pix_col = '0;
    if (visible) begin
      if (ball_hit)                    pix_col = COL_BALL;
      else if (pad_l_hit || pad_r_hit) pix_col = COL_PAD;
      else if (wall_hit)               pix_col = COL_WALL;
    end
  end

  // Output registers: sync, colour and video_on all lag the counters by one pixel.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      HSync    <= ~SYNC_POL;
      VSync    <= ~SYNC_POL;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      video_on <= 1'b0;
    end else if (pe) begin
      HSync     <= hs_nxt;
      VSync     <= vs_nxt;
      {R, G, B} <= pix_col;
      video_on  <= visible;
    end
  end

  // Frame strobe for the game logic: a single Clock wide regardless of CLK_DIV.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) frame_start <= 1'b0;
    else       frame_start <= frame_tick;
  end

endmodule

// File: doc/vga_pong_renderer.md
# vga_pong_renderer

Parametrised VGA timing generator and sprite compositor for the pong display path. It generalises the fixed 640x480 sync-plus-sprites renderer with the following features:
- parameterised timing, pixel-clock divider, sync polarity and colour depth;
- per-object colours and fixed object priority;
- frame-synchronous latching of object positions, so objects do not tear;
- a frame-start strobe for the game logic.

It sits between the game-state block, which supplies positions, and the VGA connector pins.

## Interface
Parameters:
- CLK_DIV, 2: `Clock` cycles per pixel (≥1).
- H_VA, H_FP, H_SP, H_BP, 640/16/96/48: horizontal visible area, front porch, sync pulse and back porch, in pixels.
- V_VA, V_FP, V_SP, V_BP, 480/10/2/33: vertical visible area, front porch, sync pulse and back porch, in lines.
- SYNC_POL, 0: active level of HSync and VSync.
- CW, 4: bits per colour channel.
- PAD_W, PAD_H, 15/80: paddle size in pixels.
- PAD_L_X, PAD_R_X, 0/625: paddle left edges.
- BALL, 20: ball diameter (even).
- WALL_H, 6: top and bottom wall height.
- COL_PAD, COL_BALL, COL_WALL, all-ones: {R,G,B} colours, 3*CW bits each.

Ports:
- Clock in 1: system clock.
- Reset in 1: reset; asynchronous, active-high.
- bola_x, bola_y in 10: ball top-left corner.
- barra_e_y, barra_d_y in 10: left and right paddle top edges.
- HSync, VSync out 1: sync outputs, registered.
- R, G, B out CW: colour outputs, registered.
- video_on out 1: high while the registered pixel is in the visible area.
- frame_start out 1: one-`Clock` strobe at the start of vertical blanking.

## Operation
Definitions:
- H_TOT = H_VA+H_FP+H_SP+H_BP.
- V_TOT = V_VA+V_FP+V_SP+V_BP.

Pixel enable (pe):
- Divider counts 0..CLK_DIV-1 on every `Clock` cycle.
- pe is high on the cycle where the count equals CLK_DIV-1.
- With CLK_DIV=1, pe is held high.

Counters (all state below advances only on pe):
- hcount runs 0..H_TOT-1 and wraps to 0.
- On the hcount wrap, vcount advances 0..V_TOT-1 and wraps to 0.
- No off-by-one: exactly H_TOT pixels per line and V_TOT lines per frame.

Sync:
- HSync = SYNC_POL while hcount ∈ [H_VA+H_FP, H_VA+H_FP+H_SP-1], otherwise ~SYNC_POL.
- VSync uses the same rule with the vertical constants on vcount.

Shadow positions:
- On the pe where hcount==0 and vcount==V_VA, all four position inputs are copied into shadow registers.
- frame_start is asserted for that same single `Clock` cycle.
- Rendering uses the shadow registers only; input changes mid-frame have no visible effect until the next frame.

Hit tests, at pixel (h,v):
- Arithmetic is 11-bit unsigned, so that pos+size never wraps.
- Ball hit requires h-bx ∈ [0,BALL-1] and v-by ∈ [0,BALL-1].
- Within that box, with dx=h-bx and dy=v-by, the disc test is (2dx+1-BALL)²+(2dy+1-BALL)² ≤ BALL².
- Left paddle: h ∈ [PAD_L_X, PAD_L_X+PAD_W-1] and v ∈ [ey, ey+PAD_H-1]. Right paddle uses PAD_R_X and dy.
- Walls: v < WALL_H, or v ≥ V_VA-WALL_H, for h < H_VA.

Colour:
- Priority is ball > paddle > wall > background (0).
- Outside the visible area (h ≥ H_VA or v ≥ V_VA), R=G=B=0 regardless of hits.
- Objects partly outside the visible area are clipped; the off-screen part draws nothing and nothing wraps to the other edge.

## Timing
- Every registered output corresponds to the (hcount,vcount) value present before the same pe edge. Sync, colour and video_on share this 1-pixel latency and stay mutually aligned.
- Outputs change only on pe cycles. frame_start is the exception: it is a one-`Clock` pulse.

Reset, asynchronous:
- Divider, hcount and vcount go to 0.
- HSync and VSync go to ~SYNC_POL.
- R, G, B, video_on and frame_start go to 0.
- Shadow positions go to ball (310,230) and paddles 200.
- After Reset deasserts, the first pe occurs CLK_DIV cycles later.
- Reset asserted mid-frame takes effect immediately; the next frame starts cleanly from (0,0).
- Position inputs and their shadow copies are sampled in the same cycle, with no extra latency.

## Test plan
- Timing at default parameters, run 2 frames:
  - HSync low for 96 pixels every 800 pixels;
  - VSync low for 2 lines every 525 lines;
  - frame_start pulses are exactly 800*525*2 Clock cycles apart.
- Ball with bola_x=100, bola_y=100:
  - pixel (110,110) = COL_BALL;
  - pixels (100,100) and (119,100) = 0 (corners outside the disc);
  - pixel (120,110) = 0.
- Ball at bola_x=630, overlapping the left paddle at x=0 and the right edge:
  - pixel (639,y) is the ball colour;
  - pixels h ≥ 640 are 0;
  - nothing is drawn at h = 0..9 from the ball.
- Tearing: change barra_e_y from 200 to 300 while vcount=250:
  - the remainder of the frame still shows the paddle at 200..279;
  - the next frame shows it at 300..379.
- Priority: ball placed on the wall at bola_y=0 → overlapping pixels show COL_BALL.
- Parameterised build with CLK_DIV=1, SYNC_POL=1, H_VA=320:
  - HSync is high-active and 96 pixels wide;
  - the line is 480 Clock cycles long.
- Reset pulse mid-line: outputs return to their reset values immediately; after release, hcount restarts from 0.
